// File: rtl/adder_bist.sv
// rtl/adder_bist.sv - exhaustive built-in self-test sequencer for a WIDTH-bit adder
// Optional first-failure log enabled by defining ADDER_BIST_ERRLOG_EN.
module adder_bist #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count
`ifdef ADDER_BIST_ERRLOG_EN
  ,
  output logic [2*WIDTH:0] first_fail_vec,
  output logic             first_fail_valid
`endif
);

  localparam int VW = 2*WIDTH + 1;
  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t          r_state;
  logic [VW-1:0]   r_vec;
  logic [CW-1:0]   r_settle_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [15:0]     r_err_count;
  logic [WIDTH:0]  w_expect;
  logic            w_mismatch;
`ifdef ADDER_BIST_ERRLOG_EN
  logic [VW-1:0]   r_ffv;
  logic            r_ffv_valid;
  assign first_fail_vec   = r_ffv;
  assign first_fail_valid = r_ffv_valid;
`endif

  // The vector register is the operand bus; it is zero whenever the test is idle.
  assign {dut_a, dut_b, dut_cin} = r_vec;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err_count;

  assign w_expect   = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
  assign w_mismatch = ({dut_cout, dut_sum} != w_expect);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_vec        <= '0;
      r_settle_cnt <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= '0;
`ifdef ADDER_BIST_ERRLOG_EN
      r_ffv        <= '0;
      r_ffv_valid  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_SETTLE;
            r_vec        <= '1;
            r_settle_cnt <= '0;
            r_busy       <= 1'b1;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
`ifdef ADDER_BIST_ERRLOG_EN
            r_ffv        <= '0;
            r_ffv_valid  <= 1'b0;
`endif
          end
        end
        S_SETTLE: begin
          if (abort) begin
            r_state      <= S_IDLE;
            r_vec        <= '0;
            r_settle_cnt <= '0;
            r_busy       <= 1'b0;
            r_pass       <= 1'b0;
          end else if (r_settle_cnt == CW'(SETTLE - 1)) begin
            r_state      <= S_CHECK;
            r_settle_cnt <= '0;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          // Abort takes priority: the vector under check is not scored.
          if (abort) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else begin
            if (w_mismatch && (r_err_count != 16'hFFFF))
              r_err_count <= r_err_count + 1'b1;
`ifdef ADDER_BIST_ERRLOG_EN
            if (w_mismatch && !r_ffv_valid) begin
              r_ffv       <= r_vec;
              r_ffv_valid <= 1'b1;
            end
`endif
            if (r_vec == '0) begin
              r_state <= S_DONE;
            end else begin
              r_vec   <= r_vec - 1'b1;
              r_state <= S_SETTLE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_pass  <= (r_err_count == 16'd0);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist.sv
// tb/tb_adder_bist.sv - directed self-checking bench for adder_bist (WIDTH=1/SETTLE=1 and WIDTH=2/SETTLE=2)
module tb_adder_bist;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Unit 1: WIDTH=1, SETTLE=1, adder model with optional stuck-at-0 carry-out
  logic       start1, abort1, stuck1;
  logic       a1, b1, cin1, sum1, cout1;
  logic       busy1, done1, pass1;
  logic [15:0] err1;
  logic [1:0] full1;
  assign full1 = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
  assign sum1  = full1[0];
  assign cout1 = full1[1] & ~stuck1;
`ifdef ADDER_BIST_ERRLOG_EN
  logic [2:0] ffv1;
  logic       ffvv1;
  logic [4:0] ffv2;
  logic       ffvv2;
`endif

  adder_bist #(.WIDTH(1), .SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .dut_a(a1), .dut_b(b1), .dut_cin(cin1),
    .dut_sum(sum1), .dut_cout(cout1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef ADDER_BIST_ERRLOG_EN
    , .first_fail_vec(ffv1), .first_fail_valid(ffvv1)
`endif
  );

  // Unit 2: WIDTH=2, SETTLE=2, correct adder model
  logic       start2, abort2;
  logic [1:0] a2, b2, sum2;
  logic       cin2, cout2;
  logic       busy2, done2, pass2;
  logic [15:0] err2;
  logic [2:0] full2;
  assign full2 = {1'b0, a2} + {1'b0, b2} + {2'b0, cin2};
  assign sum2  = full2[1:0];
  assign cout2 = full2[2];

  adder_bist #(.WIDTH(2), .SETTLE(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .dut_a(a2), .dut_b(b2), .dut_cin(cin2),
    .dut_sum(sum2), .dut_cout(cout2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2)
`ifdef ADDER_BIST_ERRLOG_EN
    , .first_fail_vec(ffv2), .first_fail_valid(ffvv2)
`endif
  );

  int n_checks = 0;
  int n_fails  = 0;
  int dc1 = 0;
  int dc2 = 0;
  int saved;

  always @(negedge clk) begin
    if (done1) dc1++;
    if (done2) dc2++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start1 = 0; abort1 = 0; stuck1 = 0; start2 = 0; abort2 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy1", {31'd0, busy1}, 32'd0);
    check("rst_done1", {31'd0, done1}, 32'd0);
    check("rst_pass1", {31'd0, pass1}, 32'd0);
    check("rst_err1", {16'd0, err1}, 32'd0);
    check("rst_vec1", {29'd0, a1, b1, cin1}, 32'd0);
    check("rst_vec2", {27'd0, a2, b2, cin2}, 32'd0);
    rst = 1'b0;
    tick();

    // Test 1: correct adder, 8 vectors 111..000, done 17 cycles after start edge
    start1 = 1; tick(); start1 = 0;
    check("t1_busy", {31'd0, busy1}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t1_vec%0d", k), {29'd0, a1, b1, cin1}, 32'(7 - k));
      tick(); tick();
    end
    check("t1_done_early", {31'd0, done1}, 32'd0);
    check("t1_busy_pre", {31'd0, busy1}, 32'd1);
    tick();
    check("t1_done", {31'd0, done1}, 32'd1);
    check("t1_pass", {31'd0, pass1}, 32'd1);
    check("t1_err", {16'd0, err1}, 32'd0);
    check("t1_busy_post", {31'd0, busy1}, 32'd0);
    tick();
    check("t1_done_pulse", {31'd0, done1}, 32'd0);
    check("t1_pass_hold", {31'd0, pass1}, 32'd1);

    // Test 2: carry-out stuck at 0 -> vectors 111,110,101,011 fail
    stuck1 = 1;
    start1 = 1; tick(); start1 = 0;
    check("t2_pass_clr", {31'd0, pass1}, 32'd0);
    repeat (17) tick();
    check("t2_done", {31'd0, done1}, 32'd1);
    check("t2_err", {16'd0, err1}, 32'd4);
    check("t2_pass", {31'd0, pass1}, 32'd0);
`ifdef ADDER_BIST_ERRLOG_EN
    check("t2_ffv", {29'd0, ffv1}, 32'd7);
    check("t2_ffvv", {31'd0, ffvv1}, 32'd1);
`endif
    tick();

    // Test 3: abort sampled four edges after the start edge, in CHECK of vector 110
    start1 = 1; tick(); start1 = 0;
    repeat (3) tick();
    check("t3_busy_pre", {31'd0, busy1}, 32'd1);
    saved = dc1;
    abort1 = 1; tick(); abort1 = 0;
    check("t3_busy", {31'd0, busy1}, 32'd0);
    check("t3_err", {16'd0, err1}, 32'd1);
    check("t3_pass", {31'd0, pass1}, 32'd0);
    check("t3_vec", {29'd0, a1, b1, cin1}, 32'd0);
    repeat (20) tick();
    check("t3_no_done", dc1, saved);
    check("t3_idle", {31'd0, busy1}, 32'd0);
    stuck1 = 0;

    // Test 4: asynchronous reset mid-test, then a full clean run
    start1 = 1; tick(); start1 = 0;
    repeat (6) tick();
    check("t4_busy_pre", {31'd0, busy1}, 32'd1);
    rst = 1; #1;
    check("t4_rst_busy", {31'd0, busy1}, 32'd0);
    check("t4_rst_vec", {29'd0, a1, b1, cin1}, 32'd0);
    check("t4_rst_done", {31'd0, done1}, 32'd0);
    saved = dc1;
    repeat (2) tick();
    rst = 0;
    repeat (20) tick();
    check("t4_no_done", dc1, saved);
    start1 = 1; tick(); start1 = 0;
    repeat (17) tick();
    check("t4_done", {31'd0, done1}, 32'd1);
    check("t4_pass", {31'd0, pass1}, 32'd1);

    // Test 5: WIDTH=2 SETTLE=2; start with abort (start wins), restarts during busy ignored
    saved = dc2;
    start2 = 1; abort2 = 1; tick(); start2 = 0; abort2 = 0;
    check("t5_busy", {31'd0, busy2}, 32'd1);
    check("t5_vec0", {27'd0, a2, b2, cin2}, 32'h1F);
    for (int i = 1; i <= 96; i++) begin
      start2 = (i == 10 || i == 50 || i == 95);
      tick();
    end
    start2 = 0;
    check("t5_done_early", dc2, saved);
    check("t5_busy_pre", {31'd0, busy2}, 32'd1);
    tick();
    check("t5_done", {31'd0, done2}, 32'd1);
    check("t5_pass", {31'd0, pass2}, 32'd1);
    check("t5_err", {16'd0, err2}, 32'd0);
    tick();
    check("t5_idle", {31'd0, busy2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/adder_bist.md
ADDER_BIST -- requirements
Module: adder_bist

Interface
REQ-001 Parameter WIDTH, default 4: operand width of the adder under test (1..8).
REQ-002 Parameter SETTLE, default 1: cycles each vector is held before sampling (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin exhaustive test; sampled only in IDLE.
REQ-006 abort  input  1  terminate a running test.
REQ-007 dut_a  output  WIDTH  operand A driven to adder under test, registered.
REQ-008 dut_b  output  WIDTH  operand B driven to adder under test, registered.
REQ-009 dut_cin  output  1  carry-in driven to adder under test, registered.
REQ-010 dut_sum  input  WIDTH  sum returned by adder under test.
REQ-011 dut_cout  input  1  carry-out returned by adder under test.
REQ-012 busy  output  1  high while a test runs.
REQ-013 done  output  1  one-cycle pulse at test completion.
REQ-014 pass  output  1  1 = last completed test had zero mismatches; held until next start.
REQ-015 err_count  output  16  mismatch count of current/last test.

Function
REQ-016 The block SHALL hold a vector counter V of 2*WIDTH+1 bits, mapped {dut_a, dut_b, dut_cin} = V.
REQ-017 FSM states SHALL be IDLE, SETTLE, CHECK, DONE.
REQ-018 IDLE + start=1 -> SETTLE; V loaded with all ones; err_count cleared; pass cleared; busy=1 from the next cycle.
REQ-019 SETTLE SHALL last exactly SETTLE cycles with V stable, then -> CHECK.
REQ-020 CHECK (one cycle) SHALL compare {dut_cout, dut_sum} against the WIDTH+1-bit result of dut_a + dut_b + dut_cin; a mismatch increments err_count.
REQ-021 err_count SHALL saturate at 65535.
REQ-022 CHECK with V != 0 -> V decremented by 1, -> SETTLE; CHECK with V == 0 -> DONE (vectors applied in descending order, all ones to zero, no wrap-around).
REQ-023 DONE (one cycle): done=1, busy=0, pass=(err_count==0 including the final CHECK), -> IDLE.
REQ-024 Latency: done SHALL assert 2^(2*WIDTH+1)*(SETTLE+1)+1 cycles after the edge sampling start.
REQ-025 start while not IDLE SHALL be ignored.
REQ-026 abort=1 in SETTLE or CHECK SHALL -> IDLE next cycle: busy=0, done not pulsed, pass=0, dut_* driven 0, err_count retained.
REQ-027 abort and start both high in IDLE: start wins; abort in IDLE or DONE has no effect.
REQ-028 In IDLE dut_a, dut_b, dut_cin SHALL be 0.

Reset
REQ-029 rst=1 SHALL force, asynchronously, state IDLE and dut_a=0, dut_b=0, dut_cin=0, busy=0, done=0, pass=0, err_count=0, V=0.
REQ-030 Reset mid-test SHALL discard the test; no done pulse after release; a new start after release runs a full test.

Configuration
REQ-031 Macro ADDER_BIST_ERRLOG_EN defined: extra outputs first_fail_vec (2*WIDTH+1, value of V at first mismatch of the test) and first_fail_valid (1); both cleared on start and reset; captured once per test.
REQ-032 Macro undefined: those ports and capture logic SHALL not exist; all other behaviour identical.

Verification
REQ-033 WIDTH=1, SETTLE=1, correct adder model, start pulse -> done 17 cycles later, pass=1, err_count=0, dut vectors observed 111,110,...,000.
REQ-034 WIDTH=1, SETTLE=1, adder model with dut_cout stuck at 0 -> err_count=4, pass=0; with ADDER_BIST_ERRLOG_EN, first_fail_vec=3'b111, first_fail_valid=1.
REQ-035 WIDTH=2, SETTLE=2, correct model -> done 97 cycles after start, pass=1; start pulses during busy change nothing.
REQ-036 WIDTH=1, rst asserted 6 cycles into a test, released 2 cycles later -> all outputs 0 immediately, no done; following start completes with pass=1.
REQ-037 WIDTH=1, abort at cycle 5 of a test using the stuck-cout model -> IDLE next cycle, busy=0, no done, pass=0, err_count equals mismatches counted so far (1).
